// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-arbitration controller.
package fifo_ctrl_pkg;

    localparam int unsigned PTR_WIDTH_DEFAULT = 3;

    // Which requester won the most recent accepted write.
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } gnt_state_e;

    // Wrap-bit pointer for the default geometry.
    typedef logic [PTR_WIDTH_DEFAULT:0] ptr_t;

    function automatic int unsigned fifo_depth(input int unsigned ptr_width);
        return 32'd1 << ptr_width;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    gnt_state_e last_gnt_q, last_gnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= LAST1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        gnt        = 2'b00;
        last_gnt_d = last_gnt_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_q == LAST1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        // History only moves when the granted write is actually taken.
        if (accept) begin
            if (gnt[0]) begin
                last_gnt_d = LAST0;
            end else if (gnt[1]) begin
                last_gnt_d = LAST1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller: round-robin write arbitration, wrap-bit pointers, status flags
// and registered-read sequencing for an external dual-port fifo_mem.
module fifo_wr_arb_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic [1:0]            wr_gnt,
    input  logic                  rd_req,
    output logic                  rd_data_valid,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [PTR_WIDTH:0]    mem_write_addr,
    output logic                  mem_r_en,
    output logic [PTR_WIDTH:0]    mem_read_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [PTR_WIDTH:0]    level
);

    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic               rd_valid_q;
    logic [1:0]         eligible;

    assign empty       = (wptr_q == rptr_q);
    assign full        = (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]) &&
                         (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]);
    assign level       = wptr_q - rptr_q;
    assign almost_full = (level >= (PTR_WIDTH + 1)'(AF_LEVEL));

    assign eligible = wr_req & {2{~full}};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (eligible),
        .accept (mem_w_en),
        .gnt    (wr_gnt)
    );

    assign mem_w_en       = |wr_gnt;
    assign mem_r_en       = rd_req & ~empty;
    assign mem_write_addr = wptr_q;
    assign mem_read_addr  = rptr_q;
    assign rd_data_valid  = rd_valid_q;

    always_comb begin
        mem_w_data = '0;
        unique case (wr_gnt)
            2'b01:   mem_w_data = wr_data0;
            2'b10:   mem_w_data = wr_data1;
            default: mem_w_data = '0;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (mem_w_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (mem_r_en) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= mem_r_en;
        end
    end

endmodule

// File: doc/fifo_wr_arb_ctrl.md
# fifo_wr_arb_ctrl

Single-clock controller for the dual-port FIFO storage array (`fifo_mem`). It arbitrates two write requesters round-robin onto the memory's single write port, and generates write and read pointers, `full`/`empty`/`almost_full` flags and the fill level. It also sequences the memory's registered read port and flags returned data one cycle after issue. It sits between the producers/consumer and `fifo_mem`, with both memory clocks tied to `clk`.

## Interface
- `DATA_WIDTH`, 8, payload width; must match `fifo_mem`.
- `PTR_WIDTH`, 3; FIFO capacity DEPTH = 2**PTR_WIDTH entries.
- `AF_LEVEL`, 6, `almost_full` threshold; legal range 1..DEPTH.

- `clk`  in  1  the only clock; also drives `fifo_mem` `wclk`/`rclk`.
- `rst`  in  1  synchronous, active-high reset. The top level drives the memory's active-low resets with `~rst`.
- `wr_req`  in  2  per-requester write request; level-held until granted.
- `wr_data0`  in  DATA_WIDTH  payload of requester 0.
- `wr_data1`  in  DATA_WIDTH  payload of requester 1.
- `wr_gnt`  out  2  one-hot grant, combinational; a write is accepted at the clock edge where its grant bit is high.
- `rd_req`  in  1  consumer read request.
- `rd_data_valid`  out  1  `fifo_mem` `r_data` holds the popped entry this cycle.
- `mem_w_en`  out  1  connects to `fifo_mem` `w_en`.
- `mem_w_data`  out  DATA_WIDTH  connects to `fifo_mem` `w_data`.
- `mem_write_addr`  out  PTR_WIDTH+1  connects to `fifo_mem` `write_addr`.
- `mem_r_en`  out  1  connects to `fifo_mem` `r_en`.
- `mem_read_addr`  out  PTR_WIDTH+1  connects to `fifo_mem` `read_addr`.
- `full`, `empty`, `almost_full`  out  1  status flags.
- `level`  out  PTR_WIDTH+1  occupancy, 0..DEPTH.

## Operation
- Pointers:
  - `wptr` and `rptr` are each PTR_WIDTH+1 bits; the MSB is the wrap bit. Both increment modulo 2**(PTR_WIDTH+1).
  - They drive the memory addresses directly, so the memory uses both halves of its array.
- Flags (all registered-state derived):
  - `empty` = (`wptr` == `rptr`).
  - `full` = (low bits equal and MSBs differ).
  - `level` = `wptr` − `rptr`, modulo 2**(PTR_WIDTH+1).
  - `almost_full` = (`level` >= AF_LEVEL).
- Write arbitration:
  - Eligible set = `wr_req` & {2{!full}}.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester other than `last_gnt` is granted.
  - `last_gnt` updates only on an accepted write.
  - `mem_w_en` = |`wr_gnt`. `mem_w_data` is muxed from the granted requester (0 when idle).
  - Accepted write: memory writes at `wptr`, then `wptr`++.
- Read:
  - `mem_r_en` = `rd_req` & !`empty`.
  - Accepted read: `rptr`++, and `rd_data_valid` is set next cycle.
  - `rd_req` while `empty` is ignored; no pointer change, no valid.
- Simultaneous events:
  - Write and read in the same cycle: both pointers advance and `level` is unchanged.
  - When `full`, a same-cycle read does not admit a write; the write is admitted the following cycle.
  - When `empty`, a same-cycle write does not admit a read.
- States (`last_gnt` FSM): LAST0 ↔ LAST1; a transition occurs only on a grant to the other requester.
- Reset:
  - `wptr` = `rptr` = 0, `last_gnt` = LAST1 (requester 0 wins first tie), `rd_data_valid` = 0.
  - Therefore `empty` = 1, `full` = 0, `almost_full` = 0 (AF_LEVEL ≥ 1), `level` = 0, `wr_gnt` = 0, `mem_w_en` = `mem_r_en` = 0.
  - Reset mid-operation discards contents. An in-flight `rd_data_valid` is cleared in the reset cycle.

## Timing
- Grant, `mem_w_en` and `mem_r_en` are combinational from inputs and registered state; they carry no latency.
- Write-to-visible: `empty` deasserts the cycle after the accepting edge.
- Read latency: `rd_data_valid` is high exactly 1 cycle after `mem_r_en`, aligned with memory `r_data`.
- Back-to-back reads sustain 1 entry per cycle.
- Throughput: 1 write and 1 read per cycle maximum.
- `rst` has priority over all requests on the same edge.

## Structure
- Package `fifo_ctrl_pkg` holds:
  - the `gnt_state_e` enum {LAST0, LAST1};
  - a function computing DEPTH from PTR_WIDTH;
  - the pointer type sized PTR_WIDTH+1.
- Sub-module `rr_arb2` contains the 2-way round-robin arbiter and its `last_gnt` state register. Inputs: req[1:0] and accept. Output: gnt[1:0].
- Top-level integration instantiates `fifo_wr_arb_ctrl` and `fifo_mem` together.

## Test plan
All scenarios use DATA_WIDTH=8, PTR_WIDTH=3 (DEPTH=8), AF_LEVEL=6.
1. Reset → `empty`=1, `level`=0, `wr_gnt`=00, `rd_data_valid`=0. Then `rd_req`=1 for 3 cycles → `mem_r_en` stays 0 and no valid.
2. Both `wr_req` held, `wr_data0`=0xA0, `wr_data1`=0xB1, for 4 cycles → grants 01,10,01,10; `level`=4. Reads return A0,B1,A0,B1, each with `rd_data_valid` 1 cycle after `mem_r_en`.
3. Requester 0 alone writes 0x00..0x07 → `almost_full` asserts when `level` reaches 6 and `full` when it reaches 8. A further `wr_req` gets `wr_gnt`=00 and `level` stays 8.
4. Full FIFO with `rd_req` and `wr_req[1]` in the same cycle → read accepted, write blocked. Next cycle the write is granted, and `level` goes 8→7→8.
5. Wrap: 20 write/read pairs at one per cycle → `mem_write_addr` counts 0..15,0..3. Data in equals data out, and `level` stays at most 1.
6. `rst` asserted with `level`=5 and a read in flight → next cycle `empty`=1, `level`=0, `rd_data_valid`=0.
